muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 176 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit. Each operation uses one radix-2 step per cycle,
// takes a fixed WIDTH+1 cycles from acceptance to done, and holds its results
// until the next completion.
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   IDLE  | waiting for start; hi/lo/div_zero hold the last completed result
//   CALC  | one shift-add (multiply) or restoring (divide) step per cycle
//   FIX   | sign correction, divide-by-zero override, write results, pulse done
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               sa_q, sa_d;
  logic               sb_q, sb_d;
  logic [WIDTH-1:0]   a_lat_q, a_lat_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [WIDTH-1:0]   p_hi_q, p_hi_d;
  logic [WIDTH-1:0]   p_lo_q, p_lo_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               div_zero_q, div_zero_d;

  // Signs only matter for the signed ops (op[0]=1); unsigned ops keep them 0.
  logic               acc_sa, acc_sb;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] prod;

  assign acc_sa = op[0] & a[WIDTH-1];
  assign acc_sb = op[0] & b[WIDTH-1];

  // Multiply: p_hi accumulates, p_lo shifts the multiplier out LSB-first and
  // receives the low product bits from the top.
  assign mul_sum = {1'b0, p_hi_q} + ({1'b0, m_q} & {(WIDTH+1){p_lo_q[0]}});

  // Divide: p_hi is the partial remainder, p_lo shifts the dividend out MSB-first
  // and collects quotient bits at the bottom. With m=0 the quotient ends all ones,
  // but FIX overrides the result for that case anyway.
  assign div_shift = {p_hi_q, p_lo_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, m_q};

  assign prod = {p_hi_q, p_lo_q};

  // State register and datapath flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      sa_q       <= 1'b0;
      sb_q       <= 1'b0;
      a_lat_q    <= '0;
      m_q        <= '0;
      p_hi_q     <= '0;
      p_lo_q     <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_div_q   <= is_div_d;
      sa_q       <= sa_d;
      sb_q       <= sb_d;
      a_lat_q    <= a_lat_d;
      m_q        <= m_d;
      p_hi_q     <= p_hi_d;
      p_lo_q     <= p_lo_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  // Next-state logic: acceptance, iteration steps and the final fix-up
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_div_d   = is_div_q;
    sa_d       = sa_q;
    sb_d       = sb_q;
    a_lat_d    = a_lat_q;
    m_d        = m_q;
    p_hi_d     = p_hi_q;
    p_lo_d     = p_lo_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    div_zero_d = div_zero_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          is_div_d = op[1];
          sa_d     = acc_sa;
          sb_d     = acc_sb;
          a_lat_d  = a;
          p_lo_d   = acc_sa ? -a : a;
          m_d      = acc_sb ? -b : b;
          p_hi_d   = '0;
          cnt_d    = '0;
          state_d  = CALC;
        end
      end

      CALC: begin
        if (!is_div_q) begin
          p_hi_d = mul_sum[WIDTH:1];
          p_lo_d = {mul_sum[0], p_lo_q[WIDTH-1:1]};
        end else if (!div_diff[WIDTH]) begin
          p_hi_d = div_diff[WIDTH-1:0];
          p_lo_d = {p_lo_q[WIDTH-2:0], 1'b1};
        end else begin
          p_hi_d = div_shift[WIDTH-1:0];
          p_lo_d = {p_lo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = FIX;
        end
      end

      FIX: begin
        done_d  = 1'b1;
        state_d = IDLE;
        if (!is_div_q) begin
          {hi_d, lo_d} = (sa_q ^ sb_q) ? -prod : prod;
          div_zero_d   = 1'b0;
        end else if (m_q == '0) begin
          lo_d       = '1;
          hi_d       = a_lat_q;
          div_zero_d = 1'b1;
        end else begin
          // Most-negative / -1 falls out naturally: 2^(W-1) negated wraps to itself.
          lo_d       = (sa_q ^ sb_q) ? -p_lo_q : p_lo_q;
          hi_d       = sa_q ? -p_hi_q : p_hi_q;
          div_zero_d = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (WIDTH=32): directed vector table,
// hand-written multi-cycle sequences and randomized ops against an arithmetic model.
module tb_muldiv_unit;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic         div_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int n_checks = 0;
  int n_fail   = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Reference model from plain arithmetic: returns {div_zero, hi, lo}.
  function automatic logic [64:0] model(input logic [1:0] mop, input logic [W-1:0] ma,
                                        input logic [W-1:0] mb);
    logic [63:0] up;
    longint      sp;
    int          ia, ib, q, r;
    case (mop)
      2'b00: begin
        up = {32'd0, ma} * {32'd0, mb};
        return {1'b0, up};
      end
      2'b01: begin
        sp = longint'($signed(ma)) * longint'($signed(mb));
        return {1'b0, sp};
      end
      2'b10: begin
        if (mb == 0) return {1'b1, ma, 32'hFFFF_FFFF};
        return {1'b0, ma % mb, ma / mb};
      end
      default: begin
        if (mb == 0) return {1'b1, ma, 32'hFFFF_FFFF};
        if (ma == 32'h8000_0000 && mb == 32'hFFFF_FFFF) return {1'b0, 32'd0, 32'h8000_0000};
        ia = ma;
        ib = mb;
        q  = ia / ib;
        r  = ia % ib;
        return {1'b0, r, q};
      end
    endcase
  endfunction

  function automatic logic [W-1:0] rnd_operand();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'd1;
      4:       return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  // Issue one op, scramble the inputs after acceptance, wait (bounded) for done.
  task automatic issue(input logic [1:0] iop, input logic [W-1:0] ia, input logic [W-1:0] ib,
                       output int edges, output int busy_cycles);
    @(negedge clk);
    start = 1'b1;
    op    = iop;
    a     = ia;
    b     = ib;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    op    = 2'($urandom);
    a     = 32'($urandom);
    b     = 32'($urandom);
    busy_cycles = busy ? 1 : 0;
    edges = 0;
    while (!done && edges < 100) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (busy) busy_cycles++;
    end
  endtask

  vec_t vecs[14];

  initial begin
    int edges, bcyc, ndone;
    logic [64:0] exp;
    logic [1:0]  rop;
    logic [W-1:0] ra, rb;
    logic [W-1:0] cap_hi, cap_lo;

    vecs[0]  = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[1]  = '{2'b01, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
    vecs[2]  = '{2'b11, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[3]  = '{2'b10, 32'd7,         32'd2,         32'd1,         32'd3,         1'b0};
    vecs[4]  = '{2'b10, 32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF, 1'b1};
    vecs[5]  = '{2'b00, 32'd2,         32'd3,         32'd0,         32'd6,         1'b0};
    vecs[6]  = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0};
    vecs[7]  = '{2'b11, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0};
    vecs[8]  = '{2'b11, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1};
    vecs[9]  = '{2'b11, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd3,         1'b0};
    vecs[10] = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,         1'b0};
    vecs[11] = '{2'b10, 32'd5,         32'd7,         32'd5,         32'd0,         1'b0};
    vecs[12] = '{2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0};
    vecs[13] = '{2'b00, 32'h8000_0000, 32'd2,         32'd1,         32'd0,         1'b0};

    rst_n = 1'b0;
    start = 1'b0;
    op    = 2'b00;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_divz", div_zero, 0);
    check("reset_hilo", {hi, lo}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", busy, 0);

    // Directed vector table
    for (int i = 0; i < 14; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, edges, bcyc);
      check($sformatf("vec%0d_latency", i), edges, 33);
      check($sformatf("vec%0d_busy_cycles", i), bcyc, 33);
      check($sformatf("vec%0d_hi", i), hi, vecs[i].hi);
      check($sformatf("vec%0d_lo", i), lo, vecs[i].lo);
      check($sformatf("vec%0d_divz", i), div_zero, vecs[i].dz);
      @(negedge clk);
      check($sformatf("vec%0d_done_pulse", i), done, 0);
      check($sformatf("vec%0d_hold", i), {hi, lo}, {vecs[i].hi, vecs[i].lo});
    end

    // Operand changes and start pulses while busy: one result from the latched operands
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 32'd7; b = 32'd9;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; a = 32'd100; b = 32'd200; op = 2'b11;
    repeat (5) @(negedge clk);
    start = 1'b1; op = 2'b10; a = 32'd50; b = 32'd0;
    @(negedge clk);
    start = 1'b0;
    ndone = 0; cap_hi = '0; cap_lo = '0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        cap_hi = hi;
        cap_lo = lo;
      end
    end
    check("busy_start_done_count", ndone, 1);
    check("busy_start_lo", cap_lo, 32'd63);
    check("busy_start_hi", cap_hi, 32'd0);
    check("busy_start_not_queued", busy, 0);

    // start held through an op and into its done cycle: second op accepted there
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 32'd11; b = 32'd13;
    @(posedge clk);
    edges = 0;
    @(negedge clk);
    while (!done && edges < 100) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    check("b2b_first_latency", edges, 33);
    check("b2b_first_lo", lo, 32'd143);
    op = 2'b01; a = 32'hFFFF_FFFB; b = 32'd6;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("b2b_second_accepted", busy, 1);
    edges = 0;
    while (!done && edges < 100) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    check("b2b_second_latency", edges, 33);
    check("b2b_second_result", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFE2);

    // Reset in the middle of CALC
    issue(2'b00, 32'hFFFF_FFFF, 32'd3, edges, bcyc);
    check("pre_reset_hi", hi, 32'd2);
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 32'h1234_5678; b = 32'h9ABC_DEF0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_hilo", {hi, lo}, 0);
    check("midrst_done", done, 0);
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 3) rst_n = 1'b1;
      if (done) ndone++;
    end
    check("midrst_no_done", ndone, 0);
    issue(2'b00, 32'd4, 32'd4, edges, bcyc);
    check("postrst_latency", edges, 33);
    check("postrst_lo", lo, 32'd16);
    check("postrst_hi", hi, 32'd0);

    // Randomized ops against the model
    for (int i = 0; i < 150; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = rnd_operand();
      rb  = rnd_operand();
      exp = model(rop, ra, rb);
      issue(rop, ra, rb, edges, bcyc);
      check($sformatf("rnd%0d_op%0d_latency", i, rop), edges, 33);
      check($sformatf("rnd%0d_op%0d_a%0h_b%0h_result", i, rop, ra, rb),
            {div_zero, hi, lo}, exp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
